// File: rtl/spi_tx_sched_pkg.sv
// Shared state encoding, controller register map and result codes for spi_tx_sched.
// The FSM state list depends on SPI_TX_SCHED_TIMEOUT_EN.
package spi_tx_sched_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StCrOff,
        StCrOn,
        StType,
        StSa,
        StLen,
        StWait,
        StRdSr,
        StClr,
        StReport
`ifdef SPI_TX_SCHED_TIMEOUT_EN
        , StTimeoutCr
`endif
    } state_e;

    localparam int unsigned RegCr        = 1;
    localparam int unsigned RegSr        = 2;
    localparam int unsigned RegSa        = 3;
    localparam int unsigned RegDmaLrRead = 4;
    localparam int unsigned RegPkgr0     = 7;

    localparam int unsigned SrDmaDoneBit = 0;
    localparam int unsigned SrPktErrBit  = 2;
    localparam int unsigned SrSpiErrBit  = 6;
    localparam logic [31:0] SrClrMask    = 32'h45;

    localparam logic [1:0] ErrNone    = 2'd0;
    localparam logic [1:0] ErrPktTx   = 2'd1;
    localparam logic [1:0] ErrSpiTx   = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] len;
        logic [15:0] typ;
    } desc_t;

    localparam int unsigned DescW = $bits(desc_t);

    // Bits 0 (DMA read enable) and 2 (packet TX enable) are owned here; the rest pass through.
    function automatic logic [31:0] cr_image(input logic [5:0] cfg, input logic en);
        return {26'b0, cfg & 6'b111010} | {29'b0, en, 1'b0, en};
    endfunction

endpackage

// File: rtl/spi_desc_fifo.sv
// Show-ahead synchronous descriptor FIFO; a push while full is accepted only alongside a pop.
module spi_desc_fifo #(
    parameter int unsigned WIDTH = 80,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/spi_tx_sched.sv
// Descriptor-driven CPB sequencer for the SPI slave read-DMA / packet-TX path.
// SPI_TX_SCHED_TIMEOUT_EN adds a WAIT watchdog that aborts the transfer and reports err_code 3.
module spi_tx_sched
    import spi_tx_sched_pkg::*;
#(
    parameter int unsigned     APB_AW = 5,
    parameter int unsigned     DEPTH  = 4,
    parameter int unsigned     TO_W   = 24,
    parameter logic [TO_W-1:0] TO_MAX = {TO_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_val,
    output logic              d_rdy,
    input  logic [31:0]       d_adr,
    input  logic [31:0]       d_len,
    input  logic [15:0]       d_type,
    input  logic [5:0]        cfg_cr,
    output logic              cpb_r,
    output logic              cpb_w,
    output logic [APB_AW-1:0] cpb_a,
    output logic [31:0]       cpb_d,
    input  logic [31:0]       cpb_q,
    input  logic              irq,
    output logic              busy,
    output logic              x_done,
    output logic              x_err,
    output logic [1:0]        err_code,
    output logic [15:0]       done_cnt
);
    state_e     state;
    desc_t      work;
    desc_t      head;
    desc_t      in_desc;
    logic [1:0] res_code;
    logic       full;
    logic       empty;
    logic       pop;
    logic       push;
    logic       sr_pkt;
    logic       sr_spi;
    logic       sr_ok;
    logic [1:0] sr_code;
`ifdef SPI_TX_SCHED_TIMEOUT_EN
    logic [TO_W-1:0] wd;
`endif

    assign in_desc = '{adr: d_adr, len: d_len, typ: d_type};
    assign pop     = (state == StIdle) & ~empty;
    // A full queue still accepts a push in the cycle it is popped.
    assign d_rdy   = ~full | pop;
    assign push    = d_val & d_rdy;
    assign busy    = (state != StIdle) | ~empty;

    spi_desc_fifo #(
        .WIDTH (DescW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (in_desc),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    assign sr_pkt  = |(cpb_q & (32'd1 << SrPktErrBit));
    assign sr_spi  = |(cpb_q & (32'd1 << SrSpiErrBit));
    assign sr_ok   = |(cpb_q & (32'd1 << SrDmaDoneBit));
    assign sr_code = sr_pkt ? ErrPktTx : (sr_spi ? ErrSpiTx : ErrNone);

    // Outputs are registered: each transition loads the strobes of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            work     <= '0;
            res_code <= ErrNone;
            cpb_r    <= 1'b0;
            cpb_w    <= 1'b0;
            cpb_a    <= '0;
            cpb_d    <= '0;
            x_done   <= 1'b0;
            x_err    <= 1'b0;
            err_code <= ErrNone;
            done_cnt <= '0;
`ifdef SPI_TX_SCHED_TIMEOUT_EN
            wd       <= '0;
`endif
        end else begin
            cpb_r    <= 1'b0;
            cpb_w    <= 1'b0;
            x_done   <= 1'b0;
            x_err    <= 1'b0;
            err_code <= ErrNone;
            unique case (state)
                StIdle: begin
                    if (!empty) begin
                        work  <= head;
                        state <= StCrOff;
                        cpb_w <= 1'b1;
                        cpb_a <= APB_AW'(RegCr);
                        cpb_d <= cr_image(cfg_cr, 1'b0);
                    end
                end
                StCrOff: begin
                    state <= StCrOn;
                    cpb_w <= 1'b1;
                    cpb_a <= APB_AW'(RegCr);
                    cpb_d <= cr_image(cfg_cr, 1'b1);
                end
                StCrOn: begin
                    state <= StType;
                    cpb_w <= 1'b1;
                    cpb_a <= APB_AW'(RegPkgr0);
                    cpb_d <= {16'h0, work.typ};
                end
                StType: begin
                    state <= StSa;
                    cpb_w <= 1'b1;
                    cpb_a <= APB_AW'(RegSa);
                    cpb_d <= work.adr;
                end
                StSa: begin
                    state <= StLen;
                    cpb_w <= 1'b1;
                    cpb_a <= APB_AW'(RegDmaLrRead);
                    cpb_d <= work.len;
                end
                StLen: begin
                    state <= StWait;
`ifdef SPI_TX_SCHED_TIMEOUT_EN
                    wd    <= '0;
`endif
                end
                StWait: begin
                    if (irq) begin
                        state <= StRdSr;
                        cpb_r <= 1'b1;
                        cpb_a <= APB_AW'(RegSr);
                    end
`ifdef SPI_TX_SCHED_TIMEOUT_EN
                    else if (wd == TO_MAX) begin
                        state    <= StTimeoutCr;
                        res_code <= ErrTimeout;
                        cpb_w    <= 1'b1;
                        cpb_a    <= APB_AW'(RegCr);
                        cpb_d    <= cr_image(cfg_cr, 1'b0);
                    end else begin
                        wd <= wd + TO_W'(1);
                    end
`endif
                end
                StRdSr: begin
                    if (sr_pkt || sr_spi || sr_ok) begin
                        state    <= StClr;
                        res_code <= sr_code;
                        cpb_w    <= 1'b1;
                        cpb_a    <= APB_AW'(RegSr);
                        cpb_d    <= SrClrMask;
                    end else begin
                        state <= StWait;
                    end
                end
                StClr: begin
                    state <= StReport;
                    if (res_code == ErrNone) begin
                        x_done   <= 1'b1;
                        done_cnt <= done_cnt + 16'd1;
                    end else begin
                        x_err    <= 1'b1;
                        err_code <= res_code;
                    end
                end
                StReport: begin
                    state <= StIdle;
                end
`ifdef SPI_TX_SCHED_TIMEOUT_EN
                StTimeoutCr: begin
                    state <= StClr;
                    cpb_w <= 1'b1;
                    cpb_a <= APB_AW'(RegSr);
                    cpb_d <= SrClrMask;
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

endmodule
